counter1: RTL and testbench

COUNTER1 -- requirements
Module: counter1

---
 rtl/counter1_pkg.sv | 8 +
 rtl/counter1.sv | 54 +++++
 tb/tb_counter1.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/counter1_pkg.sv
// Shared default constants for the counter1 wrapping counter.
package counter1_pkg;

  localparam int COUNTER1_DEFAULT_WIDTH       = 8;
  localparam int COUNTER1_DEFAULT_STEP        = 1;
  localparam int COUNTER1_DEFAULT_RESET_VALUE = 0;

endpackage : counter1_pkg

// File: rtl/counter1.sv
// Wrapping up-counter: adds STEP each clock and wraps to 0 once the next count would exceed MAX_VALUE.
// Optional macro COUNTER1_POWERUP_INIT_EN gives the count register a RESET_VALUE power-up value.
module counter1
  import counter1_pkg::*;
#(
  parameter int WIDTH       = COUNTER1_DEFAULT_WIDTH,
  parameter int STEP        = COUNTER1_DEFAULT_STEP,
  parameter int MAX_VALUE   = 2**WIDTH - 1,
  parameter int RESET_VALUE = COUNTER1_DEFAULT_RESET_VALUE
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);

  // Stop elaboration when the parameter set could never produce a legal count.
  if (STEP < 1 || MAX_VALUE < STEP || RESET_VALUE > MAX_VALUE) begin : g_bad_params
    $fatal(1, "counter1: illegal parameters STEP=%0d MAX_VALUE=%0d RESET_VALUE=%0d",
           STEP, MAX_VALUE, RESET_VALUE);
  end

  localparam logic [WIDTH:0]   LP_STEP_EXT  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   LP_MAX_EXT   = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] LP_RESET_VAL = WIDTH'(RESET_VALUE);

`ifdef COUNTER1_POWERUP_INIT_EN
  logic [WIDTH-1:0] r_value = LP_RESET_VAL;
`else
  logic [WIDTH-1:0] r_value;
`endif

  logic [WIDTH:0]   w_sumExt;
  logic [WIDTH-1:0] w_nextValue;

  // The sum carries one extra bit so the wrap test cannot overflow.
  always_comb begin
    w_sumExt    = {1'b0, r_value} + LP_STEP_EXT;
    w_nextValue = '0;
    if (w_sumExt <= LP_MAX_EXT) begin
      w_nextValue = w_sumExt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= LP_RESET_VAL;
    end else begin
      r_value <= w_nextValue;
    end
  end

  assign value = r_value;

endmodule : counter1

// File: tb/tb_counter1.sv
// Scoreboard bench for counter1: a default instance and a WIDTH=4/STEP=3/MAX=10/RESET=2 instance share clock and reset.
module tb_counter1;

  typedef struct {
    string      tag;
    logic [7:0] expD;
    logic [3:0] expS;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] valueD;
  logic [3:0] valueS;

  exp_t       sbQueue[$];
  int         assertCount;
  int         failCount;
  logic [7:0] modelD;
  logic [3:0] modelS;

  counter1 dutDefault (
    .value (valueD),
    .clk   (clk),
    .reset (reset)
  );

  counter1 #(
    .WIDTH       (4),
    .STEP        (3),
    .MAX_VALUE   (10),
    .RESET_VALUE (2)
  ) dutSmall (
    .value (valueS),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference counting rules, independent of the DUT's arithmetic.
  function automatic logic [7:0] nextD(input logic [7:0] v);
    int t;
    t = int'(v) + 1;
    if (t > 255) t = 0;
    return t[7:0];
  endfunction

  function automatic logic [3:0] nextS(input logic [3:0] v);
    int t;
    t = int'(v) + 3;
    if (t > 10) t = 0;
    return t[3:0];
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=empty expected=entry");
      return;
    end
    e = sbQueue.pop_front();
    assertCount++;
    assert (valueD === e.expD)
    else begin
      failCount++;
      $error("[TB] FAIL %s default observed=%h expected=%h", e.tag, valueD, e.expD);
    end
    assertCount++;
    assert (valueS === e.expS)
    else begin
      failCount++;
      $error("[TB] FAIL %s small observed=%h expected=%h", e.tag, valueS, e.expS);
    end
  endtask

  // Drives reset for the next rising edge, records the expected result, then checks on the falling edge.
  task automatic applyStimulus(input logic rst, input logic [7:0] ed, input logic [3:0] es,
                               input string tag);
    reset = rst;
    sbQueue.push_back('{tag, ed, es});
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b0;

`ifdef COUNTER1_POWERUP_INIT_EN
    #1;
    sbQueue.push_back('{"powerup", 8'h00, 4'd2});
    checkOutput();
    applyStimulus(1'b0, 8'h01, 4'd5, "powerup_inc1");
    applyStimulus(1'b0, 8'h02, 4'd8, "powerup_inc2");
`else
    #17;
    reset = 1'b1;
    @(negedge clk);
`endif

    applyStimulus(1'b1, 8'h00, 4'd2, "reset1");
    applyStimulus(1'b0, 8'h01, 4'd5, "count1");
    applyStimulus(1'b0, 8'h02, 4'd8, "count2");
    applyStimulus(1'b0, 8'h03, 4'd0, "wrap_small");

    applyStimulus(1'b1, 8'h00, 4'd2, "midcount_reset");
    applyStimulus(1'b0, 8'h01, 4'd5, "after_reset1");
    applyStimulus(1'b0, 8'h02, 4'd8, "after_reset2");
    applyStimulus(1'b0, 8'h03, 4'd0, "after_reset3");

    sbQueue.push_back('{"reset_glitch", 8'h04, 4'd3});
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput();

    applyStimulus(1'b0, 8'h05, 4'd6, "seq6");
    applyStimulus(1'b0, 8'h06, 4'd9, "seq9");
    applyStimulus(1'b0, 8'h07, 4'd0, "seq_wrap9");

    #4;
    sbQueue.push_back('{"hold_between_edges", 8'h07, 4'd0});
    checkOutput();
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h00, 4'd2, $sformatf("reset_hold%0d", i));
    end

    modelD = 8'h00;
    modelS = 4'd2;
    for (int i = 1; i <= 256; i++) begin
      modelD = nextD(modelD);
      modelS = nextS(modelS);
      applyStimulus(1'b0, modelD, modelS, $sformatf("run_edge%0d", i));
    end

    assertCount++;
    assert (valueD === 8'h00)
    else begin
      failCount++;
      $error("[TB] FAIL full_wrap observed=%h expected=00", valueD);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_counter1
